// File: rtl/wam_defs.sv
// Shared definitions for the whack-a-mole round sequencer: state encoding,
// board size and default phase timing.
package wam_defs;

  localparam int unsigned NUM_MOLES = 9;

  localparam logic [27:0] DEF_ON_INIT   = 28'd50_000_000;
  localparam logic [27:0] DEF_BTWN_INIT = 28'd25_000_000;
  localparam logic [27:0] DEF_ON_MIN    = 28'd5_000_000;
  localparam logic [27:0] DEF_BTWN_MIN  = 28'd2_500_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_ON   = 2'd2,
    ST_OVER = 2'd3
  } wam_state_e;

endpackage

// File: rtl/wam_phase_timer.sv
// Loadable 28-bit down-counter shared by the gap and lit phases; done marks
// the last cycle of the loaded length.
module wam_phase_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [27:0] load_val,
  output logic        done
);

  logic [27:0] cnt;

  // A zero length is stretched to one cycle so a phase always ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (load)
      cnt <= (load_val == '0) ? 28'd1 : load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 28'd1;
  end

  assign done = (cnt == 28'd1);

endmodule

// File: rtl/wam_game_scheduler.sv
// Whack-a-mole round sequencer: alternates gap/lit phases, judges hits and
// tracks score, lives and level with level-dependent phase lengths.
module wam_game_scheduler
  import wam_defs::*;
#(
  parameter logic [27:0] ON_INIT        = DEF_ON_INIT,
  parameter logic [27:0] BTWN_INIT      = DEF_BTWN_INIT,
  parameter logic [27:0] ON_MIN         = DEF_ON_MIN,
  parameter logic [27:0] BTWN_MIN       = DEF_BTWN_MIN,
  parameter int unsigned STEP_SHIFT     = 3,
  parameter logic [7:0]  HITS_PER_LEVEL = 8'd8,
  parameter logic [1:0]  LIVES_INIT     = 2'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] buttons,
  input  logic [3:0]           rand_pos,
  output logic [NUM_MOLES-1:0] lights,
  output logic [3:0]           position,
  output logic [7:0]           score,
  output logic [1:0]           lives,
  output logic [3:0]           level,
  output logic                 game_over,
  output logic                 busy
);

  wam_state_e state, state_d;
  logic [3:0]  position_d;
  logic [7:0]  score_d;
  logic [1:0]  lives_d;
  logic [3:0]  level_d;
  logic [7:0]  hit_cnt, hit_cnt_d;
  logic [27:0] on_len, on_len_d;
  logic [27:0] btwn_len, btwn_len_d;

  logic        tmr_load;
  logic [27:0] tmr_val;
  logic        tmr_done;

  logic [NUM_MOLES-1:0] mole;
  logic                 hit;
  logic                 wrong;
  logic [27:0]          on_dec;
  logic [27:0]          btwn_dec;

  assign mole     = {{(NUM_MOLES-1){1'b0}}, 1'b1} << position;
  assign hit      = (buttons == mole);
  assign wrong    = |(buttons & ~mole);
  assign on_dec   = on_len - (on_len >> STEP_SHIFT);
  assign btwn_dec = btwn_len - (btwn_len >> STEP_SHIFT);

  wam_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (busy),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      position <= '0;
      score    <= '0;
      lives    <= LIVES_INIT;
      level    <= '0;
      hit_cnt  <= '0;
      on_len   <= ON_INIT;
      btwn_len <= BTWN_INIT;
    end else begin
      state    <= state_d;
      position <= position_d;
      score    <= score_d;
      lives    <= lives_d;
      level    <= level_d;
      hit_cnt  <= hit_cnt_d;
      on_len   <= on_len_d;
      btwn_len <= btwn_len_d;
    end
  end

  always_comb begin
    state_d    = state;
    position_d = position;
    score_d    = score;
    lives_d    = lives;
    level_d    = level;
    hit_cnt_d  = hit_cnt;
    on_len_d   = on_len;
    btwn_len_d = btwn_len;
    tmr_load   = 1'b0;
    tmr_val    = btwn_len;

    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d    = ST_GAP;
          score_d    = '0;
          lives_d    = LIVES_INIT;
          level_d    = '0;
          hit_cnt_d  = '0;
          on_len_d   = ON_INIT;
          btwn_len_d = BTWN_INIT;
          tmr_load   = 1'b1;
          tmr_val    = BTWN_INIT;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          position_d = (rand_pos > 4'd8) ? rand_pos - 4'd9 : rand_pos;
          state_d    = ST_ON;
          tmr_load   = 1'b1;
          tmr_val    = on_len;
        end
      end
      ST_ON: begin
        // Exact hit wins over a simultaneous expiry; any stray bit is a miss.
        if (hit) begin
          score_d = (score == 8'hFF) ? score : score + 8'd1;
          if ((hit_cnt + 8'd1) >= HITS_PER_LEVEL) begin
            hit_cnt_d  = '0;
            level_d    = (level == 4'd15) ? level : level + 4'd1;
            on_len_d   = (on_dec < ON_MIN) ? ON_MIN : on_dec;
            btwn_len_d = (btwn_dec < BTWN_MIN) ? BTWN_MIN : btwn_dec;
          end else begin
            hit_cnt_d = hit_cnt + 8'd1;
          end
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = btwn_len_d;
        end else if (wrong || tmr_done) begin
          lives_d  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          tmr_load = 1'b1;
          tmr_val  = btwn_len;
          state_d  = (lives <= 2'd1) ? ST_OVER : ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign lights    = (state == ST_ON) ? mole : '0;
  assign game_over = (state == ST_OVER);
  assign busy      = (state == ST_GAP) || (state == ST_ON);

endmodule

// File: doc/wam_game_scheduler.md
# wam_game_scheduler

Round sequencer for the whack-a-mole game. Alternates gap and lit phases, picks the mole position from the tuned random number, and judges button hits against the lit mole. Tracks score, lives and level, and shortens both phase durations as the level rises. Sits between the button input stage and the board LEDs/score display, and owns all game timing.

## Interface
- ON_INIT, 28'd50_000_000, initial lit-phase length in clk cycles
- BTWN_INIT, 28'd25_000_000, initial gap-phase length in cycles
- ON_MIN, 28'd5_000_000, floor for lit-phase length
- BTWN_MIN, 28'd2_500_000, floor for gap-phase length
- STEP_SHIFT, 3, each level-up subtracts t>>STEP_SHIFT from both lengths
- HITS_PER_LEVEL, 8, hits needed per level-up
- LIVES_INIT, 3, starting lives (1..3)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle pulse; starts the game from IDLE or OVER
- buttons  in  9  single-cycle press pulses, already synchronised and edge-detected
- rand_pos  in  4  tuned random position, nominally 0..8, changes every cycle
- lights  out  9  one-hot lit mole, all 0 outside ON
- position  out  4  current mole index 0..8
- score  out  8  hit count, saturates at 255
- lives  out  2  remaining lives
- level  out  4  current level 0..15, saturates at 15
- game_over  out  1  high in OVER
- busy  out  1  high in GAP or ON

## Operation
- Reset values: state=IDLE, lights=0, position=0, score=0, lives=LIVES_INIT, level=0, game_over=0, busy=0. Internal on_len=ON_INIT, btwn_len=BTWN_INIT, hit_cnt=0.
- States: IDLE, GAP, ON, OVER.
- IDLE, start: reload score, lives, level, hit_cnt, on_len and btwn_len to init values, then go to GAP.
- GAP: timer runs for btwn_len cycles; buttons are ignored. On the last GAP cycle, sample rand_pos into position. Values 9..15 map to rand_pos-9. Then go to ON.
- ON: lights = 1<<position; timer runs for on_len cycles.
  - Hit: buttons == (1<<position) exactly. Effects: score+1 (saturating), hit_cnt+1, go to GAP.
  - Miss: any button bit outside position, or timer expiry with no hit. Effects: lives-1, then go to GAP, or to OVER if lives becomes 0.
  - Priority: hit and expiry in the same cycle counts as a hit. Correct bit plus any other bit is a miss.
- Level-up: when hit_cnt reaches HITS_PER_LEVEL, in the same transition:
  - hit_cnt=0 and level+1 (saturating).
  - on_len = max(on_len - (on_len>>STEP_SHIFT), ON_MIN); btwn_len is updated the same way against BTWN_MIN.
  - New lengths apply from the next GAP.
- OVER: lights=0, game_over=1, score/level hold. start behaves as in IDLE.
- start in GAP or ON is ignored.
- A phase length of 0 is treated as 1.

## Timing
- GAP lasts exactly btwn_len cycles and ON at most on_len cycles, counted from the first cycle in the state.
- lights goes high in the first ON cycle and clears in the cycle after the hit or expiry. The decision is registered, so the response latency is 1 cycle.
- score, lives and level update on the same edge as the ON exit.
- Async reset mid-phase returns to IDLE immediately, with all outputs at reset values.

## Structure
- Shared package/header wam_defs holds the state encoding (2-bit), the default timing constants, and NUM_MOLES=9.
- One sub-module, wam_phase_timer: a 28-bit loadable down-counter with load/enable inputs and a done flag. It is reused for both phases.
- The level-up length arithmetic stays inline: a shift, a subtract and a clamp compare.

## Test plan
Small parameters for all scenarios: ON_INIT=10, BTWN_INIT=4, ON_MIN=6, BTWN_MIN=2, STEP_SHIFT=1, HITS_PER_LEVEL=2.
1. Reset, then start with rand_pos=5 -> GAP for 4 cycles, then lights=9'h020, position=5, busy=1.
2. Press buttons=1<<5 in ON cycle 3 -> score=1, lights=0 the next cycle, state GAP.
3. Never press -> lights held for exactly 10 cycles, then lives 3→2. Repeat twice more -> lives=0, game_over=1, lights=0.
4. Two hits -> level=1, on_len=6 (10-5=5 clamped to 6), btwn_len=2. The next ON lasts 6 cycles.
5. In ON, buttons=(1<<pos)|1 -> miss (lives-1). Correct press on the final ON cycle -> hit, no life lost. rand_pos=12 -> position=3.
6. Assert reset mid-ON -> all outputs at reset values. start in OVER restarts with score=0, lives=3, level=0.
